// File: rtl/feistel_round_engine.sv
// -----------------------------------------------------------------------------
// feistel_round_engine
// Iterative Feistel state register with its own round sequencer. Holds the L/R
// halves and presents R to an external combinational f-function. Each enabled
// cycle it applies L<=R, R<=L^f. The final round skips the swap (DES pre-output
// form). The result is then held behind a valid/ready handshake.
//
// Ports
//   CLK, RST             clock (rising edge), async active-high reset
//   CLR                  synchronous abort back to IDLE with a cleared datapath
//   IN_VALID/IN_READY    input block handshake (IN_LEFT, IN_RIGHT, IN_MODE)
//   ROUND_EN             advance one round this cycle (0 = key-schedule stall)
//   R_CUR / F_OUT        R register to the f-function / its result, same cycle
//   ROUND, MODE          current round index and latched mode for the key sched
//   BUSY                 engine is computing rounds
//   OUT_VALID/OUT_READY  result handshake (OUT_LEFT, OUT_RIGHT = L/R registers)
// -----------------------------------------------------------------------------
module feistel_round_engine #(
   parameter int HALF_W = 32,
   parameter int ROUNDS = 16,
   parameter int RND_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLR,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [HALF_W-1:0] IN_LEFT,
   input  logic [HALF_W-1:0] IN_RIGHT,
   input  logic              IN_MODE,
   input  logic              ROUND_EN,
   output logic [HALF_W-1:0] R_CUR,
   input  logic [HALF_W-1:0] F_OUT,
   output logic [RND_W-1:0]  ROUND,
   output logic              MODE,
   output logic              BUSY,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [HALF_W-1:0] OUT_LEFT,
   output logic [HALF_W-1:0] OUT_RIGHT
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

   state_e             state_q, state_d;
   logic [HALF_W-1:0]  l_q, l_d, r_q, r_d;
   logic [RND_W-1:0]   round_q, round_d;
   logic               mode_q, mode_d;
   logic               ovld_q, ovld_d;

   wire last_rnd = (round_q == LAST_RND);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (CLR) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (IN_VALID)             state_d = S_RUN;
            S_RUN:  if (ROUND_EN && last_rnd) state_d = S_DONE;
            S_DONE: if (OUT_READY)            state_d = S_IDLE;
            default:                          state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs (pure state decode) ----------------
   always_comb begin
      IN_READY = (state_q == S_IDLE);
      BUSY     = (state_q == S_RUN);
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      l_d     = l_q;
      r_d     = r_q;
      round_d = round_q;
      mode_d  = mode_q;
      ovld_d  = ovld_q;
      if (CLR) begin
         // MODE is left alone: it only matters once a new block is latched
         l_d     = '0;
         r_d     = '0;
         round_d = '0;
         ovld_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (IN_VALID) begin
               l_d     = IN_LEFT;
               r_d     = IN_RIGHT;
               mode_d  = IN_MODE;
               round_d = '0;
            end
            S_RUN: if (ROUND_EN) begin
               if (last_rnd) begin
                  // final round: no swap, ROUND stays at the last index
                  l_d    = l_q ^ F_OUT;
                  ovld_d = 1'b1;
               end else begin
                  l_d     = r_q;
                  r_d     = l_q ^ F_OUT;
                  round_d = round_q + RND_W'(1);
               end
            end
            S_DONE: if (OUT_READY) begin
               // L/R are kept so the result stays observable after handoff
               ovld_d  = 1'b0;
               round_d = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         l_q     <= '0;
         r_q     <= '0;
         round_q <= '0;
         mode_q  <= 1'b0;
         ovld_q  <= 1'b0;
      end else begin
         l_q     <= l_d;
         r_q     <= r_d;
         round_q <= round_d;
         mode_q  <= mode_d;
         ovld_q  <= ovld_d;
      end
   end

   assign R_CUR     = r_q;
   assign ROUND     = round_q;
   assign MODE      = mode_q;
   assign OUT_VALID = ovld_q;
   assign OUT_LEFT  = l_q;
   assign OUT_RIGHT = r_q;

endmodule

// File: tb/tb_feistel_round_engine.sv
// Bench for feistel_round_engine: a 16-round instance carries most scenarios;
// 2-round and 1-round instances cover the short-schedule cases. Expected
// results come from a plain list-of-round-keys Feistel model.
module tb_feistel_round_engine;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // ---------------- 16-round instance ----------------
   logic        clr = 0, in_vld = 0, in_mode = 0, ren = 0, ordy = 0;
   logic [31:0] in_l = 0, in_r = 0, f = 0;
   logic        in_rdy, mode, busy, ov;
   logic [31:0] rcur, ol, orr;
   logic [3:0]  rnd;

   feistel_round_engine #(.HALF_W(32), .ROUNDS(16), .RND_W(4)) u16 (
      .CLK(CLK), .RST(RST), .CLR(clr), .IN_VALID(in_vld), .IN_READY(in_rdy),
      .IN_LEFT(in_l), .IN_RIGHT(in_r), .IN_MODE(in_mode), .ROUND_EN(ren),
      .R_CUR(rcur), .F_OUT(f), .ROUND(rnd), .MODE(mode), .BUSY(busy),
      .OUT_VALID(ov), .OUT_READY(ordy), .OUT_LEFT(ol), .OUT_RIGHT(orr));

   // ---------------- 2-round instance ----------------
   logic        b_vld = 0, b_ordy = 0;
   logic [31:0] b_l = 0, b_r = 0, b_f = 0;
   logic        b_rdy, b_mode, b_busy, b_ov;
   logic [31:0] b_rcur, b_ol, b_or;
   logic [0:0]  b_rnd;

   feistel_round_engine #(.HALF_W(32), .ROUNDS(2), .RND_W(1)) u2 (
      .CLK(CLK), .RST(RST), .CLR(1'b0), .IN_VALID(b_vld), .IN_READY(b_rdy),
      .IN_LEFT(b_l), .IN_RIGHT(b_r), .IN_MODE(1'b0), .ROUND_EN(1'b1),
      .R_CUR(b_rcur), .F_OUT(b_f), .ROUND(b_rnd), .MODE(b_mode), .BUSY(b_busy),
      .OUT_VALID(b_ov), .OUT_READY(b_ordy), .OUT_LEFT(b_ol), .OUT_RIGHT(b_or));

   // ---------------- 1-round instance ----------------
   logic        c_vld = 0, c_ordy = 0;
   logic [31:0] c_l = 0, c_r = 0, c_f = 0;
   logic        c_rdy, c_mode, c_busy, c_ov;
   logic [31:0] c_rcur, c_ol, c_or;
   logic [0:0]  c_rnd;

   feistel_round_engine #(.HALF_W(32), .ROUNDS(1), .RND_W(1)) u1 (
      .CLK(CLK), .RST(RST), .CLR(1'b0), .IN_VALID(c_vld), .IN_READY(c_rdy),
      .IN_LEFT(c_l), .IN_RIGHT(c_r), .IN_MODE(1'b1), .ROUND_EN(1'b1),
      .R_CUR(c_rcur), .F_OUT(c_f), .ROUND(c_rnd), .MODE(c_mode), .BUSY(c_busy),
      .OUT_VALID(c_ov), .OUT_READY(c_ordy), .OUT_LEFT(c_ol), .OUT_RIGHT(c_or));

   // Reference: n rounds, swap on every round but the last.
   function automatic logic [63:0] ref_feistel(input logic [31:0] l0, input logic [31:0] r0,
                                               input logic [31:0] fk [0:15], input int n);
      logic [31:0] l, r, t;
      l = l0; r = r0;
      for (int i = 0; i < n - 1; i++) begin
         t = l; l = r; r = t ^ fk[i];
      end
      l = l ^ fk[n-1];
      return {l, r};
   endfunction

   // Run one block through the 16-round instance. Stalls ROUND_EN for st_len
   // cycles when ROUND==st_at, holds OUT_READY low for rdy_hold cycles with
   // IN_VALID raised (ignored), and optionally leaves IN_VALID high (nl/nr) at
   // the output handshake so the next accept can be observed by the caller.
   task automatic run16(input logic [31:0] l0, input logic [31:0] r0, input logic md,
                        input bit frand, input logic [31:0] fconst,
                        input int st_at, input int st_len, input int rdy_hold,
                        input bit keep_vld, input logic [31:0] nl, input logic [31:0] nr);
      logic [31:0] fk [0:15];
      logic [31:0] el, er, pl, pr;
      logic [63:0] ex;
      logic [3:0]  prnd;
      int cyc, k, stl;
      bit en, pen, tmo;
      @(negedge CLK);
      total++;
      if (in_rdy !== 1'b1) begin bad++; $display("FAIL run_in_ready got=%b exp=1", in_rdy); end
      in_vld = 1; in_l = l0; in_r = r0; in_mode = md;
      @(negedge CLK);
      in_vld = 0;
      k = 0; cyc = 0; stl = st_len; pen = 1; tmo = 0;
      pl = ol; pr = orr; prnd = rnd;
      forever begin
         total++;
         if ({busy, ov, rnd} !== {1'b1, 1'b0, 4'(k)}) begin
            bad++; $display("FAIL run_round busy/ov/round got=%b/%b/%0d exp=1/0/%0d", busy, ov, rnd, k);
         end
         if (!pen) begin
            total++;
            if ({ol, orr, rnd} !== {pl, pr, prnd}) begin
               bad++; $display("FAIL stall_frozen got=%h/%h/%0d exp=%h/%h/%0d", ol, orr, rnd, pl, pr, prnd);
            end
         end
         en = !(k == st_at && stl > 0);
         if (!en) stl--;
         f = $urandom;
         if (!frand) f = fconst;
         if (en) fk[k] = f;
         ren = en; pl = ol; pr = orr; prnd = rnd;
         @(negedge CLK);
         cyc++; pen = en;
         if (en && k == 15) break;
         if (en) k++;
         if (cyc > 100) begin tmo = 1; break; end
      end
      ren = 0;
      if (tmo) begin
         total++; bad++; $display("FAIL run_timeout got=%0d cycles exp=%0d", cyc, 16 + st_len);
      end
      ex = ref_feistel(l0, r0, fk, 16);
      el = ex[63:32]; er = ex[31:0];
      total++;
      if (ov !== 1'b1 || cyc != 16 + st_len) begin
         bad++; $display("FAIL latency ov=%b cycles=%0d exp ov=1 cycles=%0d", ov, cyc, 16 + st_len);
      end
      total++;
      if ({ol, orr, rcur} !== {el, er, er}) begin
         bad++; $display("FAIL result got L=%h R=%h RCUR=%h exp L=%h R=%h", ol, orr, rcur, el, er);
      end
      total++;
      if ({mode, rnd, busy, in_rdy} !== {md, 4'd15, 1'b0, 1'b0}) begin
         bad++; $display("FAIL done_ctrl mode/round/busy/in_ready got=%b/%0d/%b/%b exp=%b/15/0/0",
                         mode, rnd, busy, in_rdy, md);
      end
      for (int h = 0; h < rdy_hold; h++) begin
         in_vld = 1; in_l = $urandom; in_r = $urandom; in_mode = ~md;
         @(negedge CLK);
         total++;
         if ({ov, in_rdy, ol, orr, mode} !== {1'b1, 1'b0, el, er, md}) begin
            bad++; $display("FAIL done_hold ov=%b in_ready=%b L=%h R=%h exp ov=1 in_ready=0 L=%h R=%h",
                            ov, in_rdy, ol, orr, el, er);
         end
      end
      in_vld = keep_vld; in_l = nl; in_r = nr; in_mode = 0;
      ordy = 1;
      @(negedge CLK);
      ordy = 0;
      total++;
      if ({ov, rnd, in_rdy, busy, ol, orr} !== {1'b0, 4'd0, 1'b1, 1'b0, el, er}) begin
         bad++; $display("FAIL handoff ov=%b round=%0d in_ready=%b busy=%b L=%h R=%h exp 0/0/1/0 L=%h R=%h",
                         ov, rnd, in_rdy, busy, ol, orr, el, er);
      end
   endtask

   task automatic test_reset;
      total++;
      if ({in_rdy, busy, ov, rnd, mode, ol, orr, rcur} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0}) begin
         bad++; $display("FAIL reset_state rdy=%b busy=%b ov=%b rnd=%0d mode=%b L=%h R=%h exp 1/0/0/0/0 zeros",
                         in_rdy, busy, ov, rnd, mode, ol, orr);
      end
      total++;
      if ({b_rdy, b_ov, b_ol, c_rdy, c_ov, c_ol} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0}) begin
         bad++; $display("FAIL reset_small b_rdy=%b b_ov=%b c_rdy=%b c_ov=%b exp 1/0/1/0", b_rdy, b_ov, c_rdy, c_ov);
      end
   endtask

   task automatic test_zero_f;
      run16(32'hA5A5A5A5, 32'h3C3C3C3C, 1'b0, 0, 32'h0, -1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 4; i++)
         run16($urandom, $urandom, 1'($urandom), 1, 0, -1, 0, $urandom_range(0, 2), 0, 0, 0);
   endtask

   task automatic test_stall;
      run16(32'hA5A5A5A5, 32'h3C3C3C3C, 1'b1, 0, 32'h0, 5, 3, 0, 0, 0, 0);
      run16($urandom, $urandom, 1'b0, 1, 0, $urandom_range(0, 15), $urandom_range(1, 4), 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back;
      logic [31:0] nl, nr;
      nl = $urandom; nr = $urandom;
      run16($urandom, $urandom, 1'b1, 1, 0, -1, 0, 4, 1, nl, nr);
      @(negedge CLK);
      in_vld = 0;
      total++;
      if ({busy, rnd, ol, orr} !== {1'b1, 4'd0, nl, nr}) begin
         bad++; $display("FAIL next_accept busy=%b rnd=%0d L=%h R=%h exp 1/0 L=%h R=%h", busy, rnd, ol, orr, nl, nr);
      end
      clr = 1;
      @(negedge CLK);
      clr = 0;
      total++;
      if ({busy, in_rdy, ol, orr} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
         bad++; $display("FAIL clr_round0 busy=%b rdy=%b L=%h R=%h exp 0/1/0/0", busy, in_rdy, ol, orr);
      end
   endtask

   task automatic test_clr;
      bit saw;
      @(negedge CLK);
      in_vld = 1; in_l = $urandom; in_r = $urandom;
      @(negedge CLK);
      in_vld = 0; ren = 1; f = $urandom;
      repeat (7) @(negedge CLK);
      total++;
      if (rnd !== 4'd7) begin bad++; $display("FAIL clr_setup round got=%0d exp=7", rnd); end
      clr = 1; in_vld = 1; ordy = 1;
      @(negedge CLK);
      clr = 0; in_vld = 0; ordy = 0; ren = 0;
      total++;
      if ({busy, in_rdy, ov, rnd, ol, orr, rcur} !== {1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0}) begin
         bad++; $display("FAIL clr_run busy=%b rdy=%b ov=%b rnd=%0d L=%h R=%h exp 0/1/0/0/0/0",
                         busy, in_rdy, ov, rnd, ol, orr);
      end
      saw = 0;
      ren = 1;
      repeat (20) begin @(negedge CLK); if (ov || busy) saw = 1; end
      ren = 0;
      total++;
      if (saw) begin bad++; $display("FAIL clr_no_output got ov/busy activity exp none"); end
      // abort from DONE
      in_vld = 1; in_l = $urandom; in_r = $urandom;
      @(negedge CLK);
      in_vld = 0; ren = 1;
      repeat (16) @(negedge CLK);
      ren = 0;
      total++;
      if (ov !== 1'b1) begin bad++; $display("FAIL clr_done_setup ov got=%b exp=1", ov); end
      clr = 1;
      @(negedge CLK);
      clr = 0;
      total++;
      if ({ov, in_rdy, rnd, ol, orr} !== {1'b0, 1'b1, 4'd0, 32'd0, 32'd0}) begin
         bad++; $display("FAIL clr_done ov=%b rdy=%b rnd=%0d L=%h R=%h exp 0/1/0/0/0", ov, in_rdy, rnd, ol, orr);
      end
   endtask

   task automatic test_async_reset;
      @(negedge CLK);
      in_vld = 1; in_l = $urandom | 32'h1; in_r = $urandom | 32'h1; in_mode = 1;
      @(negedge CLK);
      in_vld = 0; ren = 1; f = $urandom;
      repeat (7) @(negedge CLK);
      ren = 0;
      #2 RST = 1;
      #1;
      total++;
      if ({busy, ov, rnd, mode, ol, orr, in_rdy} !== {1'b0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1}) begin
         bad++; $display("FAIL async_reset busy=%b ov=%b rnd=%0d mode=%b L=%h R=%h exp 0/0/0/0/0/0",
                         busy, ov, rnd, mode, ol, orr);
      end
      @(negedge CLK);
      RST = 0;
      @(negedge CLK);
      total++;
      if ({in_rdy, busy, ol} !== {1'b1, 1'b0, 32'd0}) begin
         bad++; $display("FAIL post_reset rdy=%b busy=%b L=%h exp 1/0/0", in_rdy, busy, ol);
      end
   endtask

   task automatic test_rounds2;
      logic [31:0] fk [0:15];
      logic [63:0] ex;
      int cyc;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         b_vld = 1;
         b_l = (i == 0) ? 32'h12345678 : $urandom;
         b_r = (i == 0) ? 32'h9ABCDEF0 : $urandom;
         b_f = (i == 0) ? 32'hFFFFFFFF : $urandom;
         fk[0] = b_f; fk[1] = b_f;
         @(negedge CLK);
         b_vld = 0; cyc = 0;
         while (!b_ov && cyc < 10) begin @(negedge CLK); cyc++; end
         ex = ref_feistel(b_l, b_r, fk, 2);
         total++;
         if (cyc != 2 || {b_ol, b_or, b_rcur} !== {ex, ex[31:0]}) begin
            bad++; $display("FAIL rounds2 cycles=%0d L=%h R=%h exp cycles=2 L=%h R=%h", cyc, b_ol, b_or, ex[63:32], ex[31:0]);
         end
         b_ordy = 1;
         @(negedge CLK);
         b_ordy = 0;
         total++;
         if ({b_ov, b_rdy, b_rnd} !== {1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rounds2_handoff ov=%b rdy=%b rnd=%0d exp 0/1/0", b_ov, b_rdy, b_rnd);
         end
      end
   endtask

   task automatic test_rounds1;
      logic [31:0] fk [0:15];
      logic [63:0] ex;
      int cyc;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         c_vld = 1;
         c_l = (i == 0) ? 32'h11111111 : $urandom;
         c_r = (i == 0) ? 32'h22222222 : $urandom;
         c_f = (i == 0) ? 32'h0000FFFF : $urandom;
         fk[0] = c_f;
         @(negedge CLK);
         c_vld = 0; cyc = 0;
         while (!c_ov && cyc < 10) begin @(negedge CLK); cyc++; end
         ex = ref_feistel(c_l, c_r, fk, 1);
         total++;
         if (cyc != 1 || {c_ol, c_or, c_rnd, c_mode} !== {ex, 1'b0, 1'b1}) begin
            bad++; $display("FAIL rounds1 cycles=%0d L=%h R=%h rnd=%0d exp cycles=1 L=%h R=%h rnd=0",
                            cyc, c_ol, c_or, c_rnd, ex[63:32], ex[31:0]);
         end
         c_ordy = 1;
         @(negedge CLK);
         c_ordy = 0;
         total++;
         if ({c_ov, c_rdy, c_busy} !== {1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rounds1_handoff ov=%b rdy=%b busy=%b exp 0/1/0", c_ov, c_rdy, c_busy);
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      RST = 0;
      @(negedge CLK);
      test_reset();
      test_zero_f();
      test_random();
      test_stall();
      test_back_to_back();
      test_clr();
      test_async_reset();
      test_rounds2();
      test_rounds1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
